// File: rtl/if_fetch_pkg.sv
// ---------------------------------------------------------------------------
// if_fetch_pkg
//   Shared definitions for the instruction-fetch slice:
//     - bus widths for instruction addresses and instruction words
//     - the NOP encoding presented before the first real instruction
//     - the fetch FSM state encoding
//     - a helper that forms the byte address of the current fetch byte
//   Configuration macro used by this slice: IF_ICACHE_EN (see if_fetch.sv).
// ---------------------------------------------------------------------------
package if_fetch_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  // addi x0, x0, 0
  localparam logic [INST_W-1:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_FETCH = 2'd0,
    ST_WAIT  = 2'd1,
    ST_HOLD  = 2'd2,
    ST_DRAIN = 2'd3
  } fetchState_e;

  // Byte address of byte 'cnt' of the word at 'pc'; the 32-bit add wraps
  // naturally past 32'hFFFF_FFFF.
  function automatic logic [INST_ADDR_W-1:0] byteAddr(
    input logic [INST_ADDR_W-1:0] pc,
    input logic [1:0]             cnt
  );
    return pc + {{(INST_ADDR_W-2){1'b0}}, cnt};
  endfunction

endpackage

// File: rtl/if_fetch_if.sv
// ---------------------------------------------------------------------------
// if_fetch_if
//   Groups every non-clock signal of the fetch stage: the EX redirect request,
//   the byte-wide memory read port and the IF->ID valid/ready handshake.
//   Modports:
//     master - the fetch stage (drives memory request and ID outputs)
//     slave  - the environment (EX, memory, ID)
//   Signals:
//     redirect_i     EX requests a PC change this cycle
//     redirect_pc_i  new PC, bits [1:0] ignored
//     mem_req_o      byte read request, level, held until mem_valid_i
//     mem_addr_o     byte address, stable while mem_req_o is high
//     mem_valid_i    read data returned this cycle
//     mem_data_i     returned byte
//     if_valid_o     {if_pc_o, if_inst_o} valid for ID
//     id_ready_i     ID accepts this cycle
//     if_pc_o        PC of the presented instruction
//     if_inst_o      presented instruction
// ---------------------------------------------------------------------------
interface if_fetch_if;
  import if_fetch_pkg::*;

  logic                   redirect_i;
  logic [INST_ADDR_W-1:0] redirect_pc_i;
  logic                   mem_req_o;
  logic [INST_ADDR_W-1:0] mem_addr_o;
  logic                   mem_valid_i;
  logic [7:0]             mem_data_i;
  logic                   if_valid_o;
  logic                   id_ready_i;
  logic [INST_ADDR_W-1:0] if_pc_o;
  logic [INST_W-1:0]      if_inst_o;

  modport master (
    input  redirect_i, redirect_pc_i, mem_valid_i, mem_data_i, id_ready_i,
    output mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o
  );

  modport slave (
    output redirect_i, redirect_pc_i, mem_valid_i, mem_data_i, id_ready_i,
    input  mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o
  );

endinterface

// File: rtl/if_fetch_icache.sv
// ---------------------------------------------------------------------------
// if_icache
//   Direct-mapped instruction cache holding one 32-bit word per line.
//   Only instantiated by if_fetch when IF_ICACHE_EN is defined.
//   index = addr[2 +: log2(LINES)], tag = the address bits above the index.
//   Ports:
//     clk           clock, rising edge
//     rst           synchronous active-high reset, invalidates every line
//     i_lookupAddr  word address to look up (bits [1:0] ignored)
//     o_hit         line valid and tag matches (combinational)
//     o_word        word stored in the indexed line (combinational)
//     i_we          write the line selected by i_writeAddr
//     i_writeAddr   word address being filled
//     i_writeWord   word being filled
// ---------------------------------------------------------------------------
module if_icache
  import if_fetch_pkg::*;
#(
  parameter int LINES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [INST_ADDR_W-1:0] i_lookupAddr,
  output logic                   o_hit,
  output logic [INST_W-1:0]      o_word,
  input  logic                   i_we,
  input  logic [INST_ADDR_W-1:0] i_writeAddr,
  input  logic [INST_W-1:0]      i_writeWord
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = INST_ADDR_W - 2 - IDX_W;

  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [INST_W-1:0] r_word [LINES];

  logic [IDX_W-1:0] w_rdIdx;
  logic [TAG_W-1:0] w_rdTag;
  logic [IDX_W-1:0] w_wrIdx;
  logic [TAG_W-1:0] w_wrTag;
  logic [3:0]       w_unusedLow;

  // Byte-offset bits never select anything in a word-per-line cache.
  assign w_unusedLow = {i_lookupAddr[1:0], i_writeAddr[1:0]};

  assign w_rdIdx = i_lookupAddr[2 +: IDX_W];
  assign w_rdTag = i_lookupAddr[INST_ADDR_W-1 -: TAG_W];
  assign w_wrIdx = i_writeAddr[2 +: IDX_W];
  assign w_wrTag = i_writeAddr[INST_ADDR_W-1 -: TAG_W];

  assign o_hit  = r_valid[w_rdIdx] && (r_tag[w_rdIdx] == w_rdTag);
  assign o_word = r_word[w_rdIdx];

  // Valid bits are the only state that reset has to touch.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_valid <= '0;
    end else if (i_we) begin
      r_valid[w_wrIdx] <= 1'b1;
    end
  end

  // Tag and data storage; contents are meaningless until the valid bit is set.
  always_ff @(posedge clk) begin
    if (i_we) begin
      r_tag[w_wrIdx]  <= w_wrTag;
      r_word[w_wrIdx] <= i_writeWord;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// ---------------------------------------------------------------------------
// if_fetch
//   Instruction-fetch stage. Assembles 32-bit little-endian instructions from
//   four single-byte reads on the unified memory port and presents
//   {if_pc_o, if_inst_o} to ID with a valid/ready handshake. EX may redirect
//   the PC at any time; a redirect that lands while a byte read is still
//   outstanding parks the FSM in DRAIN until that read returns and is dropped.
//   Optional feature: define IF_ICACHE_EN to add a direct-mapped I-cache
//   (if_icache) that returns hits in one cycle with no memory traffic.
//   Parameters:
//     RESET_PC      first PC fetched after reset
//     ICACHE_LINES  I-cache line count (power of 2, >= 2)
//   Ports:
//     clk  clock, rising edge
//     rst  synchronous active-high reset
//     bus  if_fetch_if.master (redirect, memory port, ID handshake)
// ---------------------------------------------------------------------------
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [INST_ADDR_W-1:0] RESET_PC     = 32'h0000_0000,
  parameter int                     ICACHE_LINES = 16
) (
  input  logic       clk,
  input  logic       rst,
  if_fetch_if.master bus
);

  fetchState_e            r_state;
  logic [INST_ADDR_W-1:0] r_pc;
  logic [1:0]             r_cnt;
  logic [23:0]            r_asm;
  logic                   r_memReq;
  logic [INST_ADDR_W-1:0] r_memAddr;
  logic                   r_ifValid;
  logic [INST_ADDR_W-1:0] r_ifPc;
  logic [INST_W-1:0]      r_ifInst;

  logic [INST_W-1:0]      w_fullWord;
  logic                   w_cacheHit;
  logic [INST_W-1:0]      w_cacheWord;

  // The last byte goes straight from the bus into the completed word.
  assign w_fullWord = {bus.mem_data_i, r_asm};

`ifdef IF_ICACHE_EN
  logic w_fillWe;
  logic w_lookupHit;

  // A fill happens whenever the fourth byte lands, even under a redirect:
  // the assembled word is still correct for r_pc.
  assign w_fillWe = (r_state == ST_WAIT) && bus.mem_valid_i && (r_cnt == 2'd3);

  if_icache #(
    .LINES (ICACHE_LINES)
  ) u_icache (
    .clk          (clk),
    .rst          (rst),
    .i_lookupAddr (r_pc),
    .o_hit        (w_lookupHit),
    .o_word       (w_cacheWord),
    .i_we         (w_fillWe),
    .i_writeAddr  (r_pc),
    .i_writeWord  (w_fullWord)
  );

  // Only a fresh word (no bytes collected yet) may be served from the cache.
  assign w_cacheHit = w_lookupHit && (r_cnt == 2'd0);
`else
  localparam int IDX_W = $clog2(ICACHE_LINES);
  logic [IDX_W-1:0] w_unusedIdx;

  // No cache storage: every fetch takes the four-byte path.
  assign w_cacheHit  = 1'b0;
  assign w_cacheWord = NOP_INST;
  assign w_unusedIdx = r_pc[2 +: IDX_W];
`endif

  // Fetch FSM with all outputs registered. Redirect outranks both the ID
  // handshake and byte capture. Leaving WAIT through a redirect without the
  // data in hand goes to DRAIN, which keeps the request up so the memory
  // protocol (request held until valid) is honoured, then drops the byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_FETCH;
      r_pc      <= RESET_PC;
      r_cnt     <= 2'd0;
      r_asm     <= '0;
      r_memReq  <= 1'b0;
      r_memAddr <= '0;
      r_ifValid <= 1'b0;
      r_ifPc    <= '0;
      r_ifInst  <= NOP_INST;
    end else if (bus.redirect_i) begin
      r_pc      <= {bus.redirect_pc_i[INST_ADDR_W-1:2], 2'b00};
      r_cnt     <= 2'd0;
      r_ifValid <= 1'b0;
      if (((r_state == ST_WAIT) || (r_state == ST_DRAIN)) && !bus.mem_valid_i) begin
        r_state  <= ST_DRAIN;
        r_memReq <= 1'b1;
      end else begin
        r_state  <= ST_FETCH;
        r_memReq <= 1'b0;
      end
    end else begin
      case (r_state)
        ST_FETCH: begin
          if (w_cacheHit) begin
            r_ifValid <= 1'b1;
            r_ifPc    <= r_pc;
            r_ifInst  <= w_cacheWord;
            r_state   <= ST_HOLD;
          end else begin
            r_memReq  <= 1'b1;
            r_memAddr <= byteAddr(r_pc, r_cnt);
            r_state   <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (bus.mem_valid_i) begin
            r_memReq <= 1'b0;
            if (r_cnt != 2'd3) begin
              case (r_cnt)
                2'd0:    r_asm[7:0]   <= bus.mem_data_i;
                2'd1:    r_asm[15:8]  <= bus.mem_data_i;
                2'd2:    r_asm[23:16] <= bus.mem_data_i;
                default: ;
              endcase
              r_cnt   <= r_cnt + 2'd1;
              r_state <= ST_FETCH;
            end else begin
              r_cnt     <= 2'd0;
              r_ifValid <= 1'b1;
              r_ifPc    <= r_pc;
              r_ifInst  <= w_fullWord;
              r_state   <= ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (bus.id_ready_i) begin
            r_ifValid <= 1'b0;
            r_pc      <= r_pc + 32'd4;
            r_state   <= ST_FETCH;
          end
        end
        ST_DRAIN: begin
          if (bus.mem_valid_i) begin
            r_memReq <= 1'b0;
            r_state  <= ST_FETCH;
          end
        end
        default: r_state <= ST_FETCH;
      endcase
    end
  end

  assign bus.mem_req_o  = r_memReq;
  assign bus.mem_addr_o = r_memAddr;
  assign bus.if_valid_o = r_ifValid;
  assign bus.if_pc_o    = r_ifPc;
  assign bus.if_inst_o  = r_ifInst;

endmodule

// File: tb/tb_if_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_fetch
//   Directed bench for if_fetch. A behavioural byte memory with programmable
//   latency answers requests; expected {pc, inst} pairs are queued as the
//   stimulus is issued and popped whenever an IF->ID handshake occurs.
//   Extra cache-latency expectations apply when IF_ICACHE_EN is defined.
// ---------------------------------------------------------------------------
module tb_if_fetch;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
  } exp_t;

`ifdef IF_ICACHE_EN
  localparam int HIT_LAT  = 1;
  localparam int HIT_REQS = 0;
`else
  localparam int HIT_LAT  = 8;
  localparam int HIT_REQS = 4;
`endif

  logic clk = 1'b0;
  logic rst;
  int   vecCnt   = 0;
  int   missCnt  = 0;
  int   memDelay = 0;
  int   memAge   = 0;
  exp_t expQ[$];

  if_fetch_if bus ();

  if_fetch #(
    .RESET_PC     (32'h0000_0000),
    .ICACHE_LINES (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10-time-unit clock.
  always #5 clk = ~clk;

  // Memory image: the test word at 0..3, an address-derived pattern elsewhere.
  function automatic logic [7:0] memByte(input logic [31:0] a);
    case (a)
      32'd0:   return 8'h13;
      32'd1:   return 8'h05;
      32'd2:   return 8'h10;
      32'd3:   return 8'h00;
      default: return a[7:0] ^ a[15:8] ^ 8'h5A;
    endcase
  endfunction

  function automatic logic [31:0] expWord(input logic [31:0] pc);
    return {memByte(pc + 32'd3), memByte(pc + 32'd2), memByte(pc + 32'd1), memByte(pc)};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecCnt++;
    assert (obs === exp) else begin
      missCnt++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic redir, input logic [31:0] rpc, input logic rdy);
    bus.redirect_i    = redir;
    bus.redirect_pc_i = rpc;
    bus.id_ready_i    = rdy;
  endtask

  task automatic waitValid(input string tag, input int maxCyc, output int cyc);
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (bus.if_valid_o !== 1'b1 && cyc < maxCyc);
    if (bus.if_valid_o !== 1'b1) checkOutput({tag, "_valid_timeout"}, 32'(bus.if_valid_o), 32'd1);
  endtask

  // Waits for a fresh rising edge of mem_req_o.
  task automatic waitReqRise(input string tag, input int maxCyc);
    int n;
    bit sawLow;
    bit found;
    n      = 0;
    found  = 1'b0;
    sawLow = (bus.mem_req_o !== 1'b1);
    while (n < maxCyc && !found) begin
      @(negedge clk);
      n++;
      if (bus.mem_req_o !== 1'b1) sawLow = 1'b1;
      else if (sawLow) found = 1'b1;
    end
    if (!found) checkOutput({tag, "_req_timeout"}, 32'(found), 32'd1);
  endtask

  // Memory model: answers once the request has been seen for more than
  // memDelay cycles; memDelay 0 returns data in the first request cycle.
  initial begin
    bus.mem_valid_i = 1'b0;
    bus.mem_data_i  = 8'h00;
    forever begin
      @(negedge clk);
      #1;
      if (bus.mem_req_o === 1'b1) begin
        memAge++;
        if (memAge > memDelay) begin
          bus.mem_valid_i = 1'b1;
          bus.mem_data_i  = memByte(bus.mem_addr_o);
        end else begin
          bus.mem_valid_i = 1'b0;
          bus.mem_data_i  = 8'h00;
        end
      end else begin
        memAge          = 0;
        bus.mem_valid_i = 1'b0;
      end
    end
  end

  // Scoreboard: every handshake must match the oldest queued expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst === 1'b0 && bus.if_valid_o === 1'b1 && bus.id_ready_i === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("spurious_handshake", 32'(expQ.size()), 32'd1);
        end else begin
          e = expQ.pop_front();
          checkOutput("hs_pc", bus.if_pc_o, e.pc);
          checkOutput("hs_inst", bus.if_inst_o, e.inst);
        end
      end
    end
  end

  // Directed sequence.
  initial begin
    int cyc;
    int n;
    int reqSeen;
    logic [31:0] holdPc;
    logic [31:0] holdInst;

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("rst_mem_req", 32'(bus.mem_req_o), 32'd0);
    checkOutput("rst_mem_addr", bus.mem_addr_o, 32'h0);
    checkOutput("rst_if_valid", 32'(bus.if_valid_o), 32'd0);
    checkOutput("rst_if_pc", bus.if_pc_o, 32'h0);
    checkOutput("rst_if_inst", bus.if_inst_o, 32'h0000_0013);

    // Reset-to-first-instruction latency and the word at address 0.
    expQ.push_back('{32'h0, 32'h0010_0513});
    rst = 1'b0;
    waitValid("first", 20, cyc);
    checkOutput("first_latency", 32'(cyc), 32'd8);
    waitReqRise("after_first", 20);
    checkOutput("next_addr_4", bus.mem_addr_o, 32'h4);

    // Back-pressure: word at pc 4 must sit still while ID stalls.
    bus.id_ready_i = 1'b0;
    expQ.push_back('{32'h4, expWord(32'h4)});
    waitValid("pc4", 20, cyc);
    holdPc   = 32'h4;
    holdInst = expWord(32'h4);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold_valid", 32'(bus.if_valid_o), 32'd1);
      checkOutput("hold_pc", bus.if_pc_o, holdPc);
      checkOutput("hold_inst", bus.if_inst_o, holdInst);
      checkOutput("hold_mem_req", 32'(bus.mem_req_o), 32'd0);
    end
    expQ.push_back('{32'h8, expWord(32'h8)});
    applyStimulus(1'b0, 32'h0, 1'b1);

    // Redirect in the same cycle as the handshake at pc 8.
    waitValid("pc8", 20, cyc);
    applyStimulus(1'b1, 32'h0000_0040, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("redir_clears_valid", 32'(bus.if_valid_o), 32'd0);
    memDelay = 3;
    waitReqRise("pc40", 20);
    checkOutput("redir_addr_40", bus.mem_addr_o, 32'h0000_0040);

    // Redirect while byte 2 is outstanding on slow memory -> DRAIN.
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.mem_req_o === 1'b1 && bus.mem_addr_o === 32'h42) && n < 60);
    checkOutput("byte2_addr", bus.mem_addr_o, 32'h0000_0042);
    applyStimulus(1'b1, 32'h0000_1007, 1'b1);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    checkOutput("drain_req_held", 32'(bus.mem_req_o), 32'd1);
    checkOutput("drain_addr_held", bus.mem_addr_o, 32'h0000_0042);
    checkOutput("drain_valid", 32'(bus.if_valid_o), 32'd0);
    waitReqRise("after_drain", 20);
    checkOutput("drain_next_addr", bus.mem_addr_o, 32'h0000_1004);
    memDelay = 0;
    expQ.push_back('{32'h0000_1004, expWord(32'h0000_1004)});
    waitValid("pc1004", 30, cyc);

    // PC wrap from the top of the address space.
    @(negedge clk);
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1);
    expQ.push_back('{32'hFFFF_FFFC, expWord(32'hFFFF_FFFC)});
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitValid("pc_top", 20, cyc);
    expQ.push_back('{32'h0, 32'h0010_0513});
    waitValid("pc_wrap", 20, cyc);

    // Loop back to 0: a cache hit when the I-cache is built in.
    @(negedge clk);
    applyStimulus(1'b1, 32'h0, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0);
    n       = 0;
    reqSeen = 0;
    do begin
      @(negedge clk);
      n++;
      if (bus.mem_req_o === 1'b1) reqSeen++;
    end while (bus.if_valid_o !== 1'b1 && n < 20);
    checkOutput("loop_latency", 32'(n), 32'(HIT_LAT));
    checkOutput("loop_req_cycles", 32'(reqSeen), 32'(HIT_REQS));
    checkOutput("loop_pc", bus.if_pc_o, 32'h0);
    checkOutput("loop_inst", bus.if_inst_o, 32'h0010_0513);

    // Same cache index, different tag: must go to memory.
    applyStimulus(1'b1, 32'h0000_0040, 1'b0);
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 1'b0);
    checkOutput("alias_valid_clear", 32'(bus.if_valid_o), 32'd0);
    waitReqRise("alias", 20);
    checkOutput("alias_addr", bus.mem_addr_o, 32'h0000_0040);
    expQ.push_back('{32'h0000_0040, expWord(32'h0000_0040)});
    applyStimulus(1'b0, 32'h0, 1'b1);
    waitValid("alias_word", 20, cyc);

    repeat (3) @(negedge clk);
    checkOutput("queue_drained", 32'(expQ.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
